// File: rtl/des_block_loader_if.sv
// Byte-stream input and ciphertext output handshakes of des_block_loader.
//   in_byte/in_valid/in_last -> loader, in_ready <- loader
//   ct_out/ct_valid/ct_last  <- loader, ct_ready -> loader
// slave is the loader's view; master is the producer/consumer view.
interface des_block_loader_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] ct_out;
  logic        ct_valid;
  logic        ct_ready;
  logic        ct_last;

  modport master (
    output in_byte, in_valid, in_last, ct_ready,
    input  in_ready, ct_out, ct_valid, ct_last
  );

  modport slave (
    input  in_byte, in_valid, in_last, ct_ready,
    output in_ready, ct_out, ct_valid, ct_last
  );
endinterface

// File: rtl/des_block_loader.sv
// Front-end sequencer for the DES encrypt stage. Packs a plaintext byte stream
// into 64-bit blocks (first byte in [63:56]), applies PKCS#5 padding to the
// final block, holds each block on msg_out for ENC_LATENCY cycles, captures
// enc_in and offers it downstream via a valid/ready handshake.
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   bus       - slave side of des_block_loader_if (byte input, ct output)
//   msg_out   - block driven to the encrypt stage msg input
//   enc_in    - ciphertext from the encrypt stage output
//   busy      - high outside FILL or while a block is partially filled
module des_block_loader #(
  parameter int ENC_LATENCY = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  des_block_loader_if.slave   bus,
  output logic [63:0]         msg_out,
  input  logic [63:0]         enc_in,
  output logic                busy
);

  typedef enum logic [1:0] {FILL, HOLD, OUT} state_t;

  localparam logic [63:0] PAD_BLOCK = 64'h0808080808080808;

  state_t           state, state_nx;
  logic [2:0]       cnt;
  logic [CNT_W-1:0] lat;
  logic             pad_pending;
  logic             last_flag;
  logic [63:0]      ct_out_q;
  logic             ct_valid_q;
  logic             ct_last_q;
  logic [63:0]      msg_nx;

  logic in_ready;
  logic accept;
  logic lat_done;
  logic hs;

  assign in_ready = (state == FILL);
  assign accept   = bus.in_valid && in_ready;
  assign lat_done = (lat == CNT_W'(ENC_LATENCY - 1));
  assign hs       = ct_valid_q && bus.ct_ready;

  assign bus.in_ready = in_ready;
  assign bus.ct_out   = ct_out_q;
  assign bus.ct_valid = ct_valid_q;
  assign bus.ct_last  = ct_last_q;
  assign busy         = (state != FILL) || (cnt != 3'd0);

  always_comb begin
    state_nx = state;
    case (state)
      FILL: if (accept && (bus.in_last || cnt == 3'd7)) state_nx = HOLD;
      HOLD: if (lat_done) state_nx = OUT;
      OUT:  if (hs) state_nx = pad_pending ? HOLD : FILL;
      default: state_nx = FILL;
    endcase
  end

  // The accepted byte and, on a short final block, every slot after it are
  // written in the same cycle so msg_out is complete on entry to HOLD.
  always_comb begin
    msg_nx = msg_out;
    if (state == FILL && accept) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (3'(i) == cnt)
          msg_nx[63-8*i -: 8] = bus.in_byte;
        else if (bus.in_last && 3'(i) > cnt)
          msg_nx[63-8*i -: 8] = 8'd7 - {5'd0, cnt};
      end
    end else if (state == OUT && hs) begin
      msg_nx = pad_pending ? PAD_BLOCK : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= '0;
      lat         <= '0;
      pad_pending <= 1'b0;
      last_flag   <= 1'b0;
      msg_out     <= '0;
      ct_out_q    <= '0;
      ct_valid_q  <= 1'b0;
      ct_last_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      msg_out <= msg_nx;
      lat     <= (state == HOLD) ? lat + 1'b1 : '0;
      case (state)
        FILL: if (accept) begin
          cnt <= bus.in_last ? 3'd0 : cnt + 3'd1;
          if (bus.in_last && cnt == 3'd7) pad_pending <= 1'b1;
          else if (bus.in_last)           last_flag   <= 1'b1;
        end
        HOLD: if (lat_done) begin
          ct_out_q   <= enc_in;
          ct_last_q  <= last_flag && !pad_pending;
          ct_valid_q <= 1'b1;
        end
        OUT: if (hs) begin
          ct_valid_q <= 1'b0;
          if (pad_pending) begin
            pad_pending <= 1'b0;
            last_flag   <= 1'b1;
          end else begin
            last_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_block_loader.sv
module tb_des_block_loader;
  localparam int LAT0 = 16;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_block_loader_if bif0 ();
  des_block_loader_if bif1 ();

  logic [63:0] msg0, msg1, enc0, enc1;
  logic        busy0, busy1;

  des_block_loader #(.ENC_LATENCY(LAT0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bif0), .msg_out(msg0), .enc_in(enc0), .busy(busy0));
  des_block_loader #(.ENC_LATENCY(LAT1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bif1), .msg_out(msg1), .enc_in(enc1), .busy(busy1));

  // stimulus drivers, indexed by DUT
  logic [7:0] ib [2];
  logic       iv [2];
  logic       il [2];
  logic       cr [2];
  assign bif0.in_byte = ib[0]; assign bif0.in_valid = iv[0];
  assign bif0.in_last = il[0]; assign bif0.ct_ready = cr[0];
  assign bif1.in_byte = ib[1]; assign bif1.in_valid = iv[1];
  assign bif1.in_last = il[1]; assign bif1.ct_ready = cr[1];

  // observed outputs, indexed by DUT
  logic        rdy [2];
  logic        ctv [2];
  logic        ctl [2];
  logic        bsy [2];
  logic [63:0] cto [2];
  logic [63:0] msg [2];
  assign rdy[0] = bif0.in_ready; assign rdy[1] = bif1.in_ready;
  assign ctv[0] = bif0.ct_valid; assign ctv[1] = bif1.ct_valid;
  assign ctl[0] = bif0.ct_last;  assign ctl[1] = bif1.ct_last;
  assign cto[0] = bif0.ct_out;   assign cto[1] = bif1.ct_out;
  assign msg[0] = msg0;          assign msg[1] = msg1;
  assign bsy[0] = busy0;         assign bsy[1] = busy1;

  // Stand-in encrypt stage: output is a fixed scramble of msg, but only after
  // msg has been stable long enough; garbage is shown before that.
  function automatic logic [63:0] fenc(input logic [63:0] m);
    return {m[40:0], m[63:41]} ^ 64'h5A17C3E90B6DF248;
  endfunction

  logic [63:0] seen0 = '0, seen1 = '0;
  int          age0 = 0, age1 = 0;
  always @(negedge clk) begin
    if (msg0 !== seen0) begin seen0 <= msg0; age0 <= 0; end
    else if (age0 < 1000) age0 <= age0 + 1;
    if (msg1 !== seen1) begin seen1 <= msg1; age1 <= 0; end
    else if (age1 < 1000) age1 <= age1 + 1;
  end
  assign enc0 = (age0 >= LAT0 - 1) ? fenc(msg0) : 64'hBAD0BAD0BAD0BAD0;
  assign enc1 = (age1 >= LAT1 - 1) ? fenc(msg1) : 64'hBAD1BAD1BAD1BAD1;

  typedef struct {
    logic [63:0] m;
    logic [63:0] ct;
    logic        last;
  } exp_t;
  exp_t sb[$];

  int nchk = 0;
  int nerr = 0;

  logic [7:0] bbuf [8];
  int         nb = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Build the expected block(s) from the bench's own byte buffer.
  task automatic push_block(input logic last);
    logic [63:0] m;
    for (int i = 0; i < 8; i++)
      m[63-8*i -: 8] = (i < nb) ? bbuf[i] : 8'(8 - nb);
    if (nb == 8 && last) begin
      sb.push_back('{m: m, ct: fenc(m), last: 1'b0});
      sb.push_back('{m: 64'h0808080808080808, ct: fenc(64'h0808080808080808), last: 1'b1});
    end else begin
      sb.push_back('{m: m, ct: fenc(m), last: last});
    end
    nb = 0;
  endtask

  // Called and returning at #1 after a clock edge.
  task automatic send_byte(input int d, input logic [7:0] b, input logic last, input int gap);
    int t;
    repeat (gap) begin
      ib[d] = 8'hEE; iv[d] = 1'b0; il[d] = 1'b1;
      @(posedge clk); #1;
    end
    ib[d] = b; iv[d] = 1'b1; il[d] = last;
    t = 0;
    while (!rdy[d] && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    iv[d] = 1'b0; il[d] = 1'b0;
    bbuf[nb] = b;
    nb++;
    if (last || nb == 8) push_block(last);
  endtask

  task automatic send_block(input int d, input logic [7:0] base, input int n,
                            input logic last, input int gap);
    for (int i = 0; i < n; i++)
      send_byte(d, base + 8'(i), last && (i == n - 1), gap);
  endtask

  // Called at #1 after the edge that entered HOLD; returns at #1 after the
  // handshake edge.
  task automatic expect_block(input int d, input int lat, input int stall);
    exp_t        e;
    int          n;
    logic        stable;
    logic [63:0] snap_ct, snap_m;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (!ctv[d] && n < 400) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(n), 64'(lat));
    chk("msg_out", msg[d], e.m);
    chk("ct_out", cto[d], e.ct);
    chk("ct_last", {63'd0, ctl[d]}, {63'd0, e.last});
    chk("out_in_ready", {63'd0, rdy[d]}, 64'd0);
    if (stall > 0) begin
      stable = 1'b1;
      snap_ct = cto[d];
      snap_m  = msg[d];
      repeat (stall) begin
        ib[d] = 8'h77; iv[d] = 1'b1; il[d] = 1'b1;
        @(posedge clk); #1;
        if (cto[d] !== snap_ct || msg[d] !== snap_m || ctv[d] !== 1'b1 || rdy[d] !== 1'b0)
          stable = 1'b0;
      end
      iv[d] = 1'b0; il[d] = 1'b0;
      chk("stall_stable", {63'd0, stable}, 64'd1);
    end
    cr[d] = 1'b1;
    @(posedge clk); #1;
    cr[d] = 1'b0;
    chk("ct_valid_drop", {63'd0, ctv[d]}, 64'd0);
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_busy"}, {63'd0, bsy[d]}, 64'd0);
    chk({tag, "_msg"}, msg[d], 64'd0);
    chk({tag, "_in_ready"}, {63'd0, rdy[d]}, 64'd1);
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk_idle(d, tag);
    chk({tag, "_ct_valid"}, {63'd0, ctv[d]}, 64'd0);
    chk({tag, "_ct_last"}, {63'd0, ctl[d]}, 64'd0);
    chk({tag, "_ct_out"}, cto[d], 64'd0);
  endtask

  initial begin
    logic rose;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ib[d] = '0; iv[d] = 1'b0; il[d] = 1'b0; cr[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    rst = 1'b0;
    @(posedge clk); #1;

    // full block without last
    for (int i = 0; i < 8; i++) begin
      logic [63:0] v;
      v = 64'h0123456789ABCDEF;
      send_byte(0, v[63-8*i -: 8], 1'b0, 0);
    end
    expect_block(0, LAT0, 0);
    chk_idle(0, "after_full");

    // short final block, PKCS#5 fill 05
    send_byte(0, 8'hAA, 1'b0, 0);
    send_byte(0, 8'hBB, 1'b0, 0);
    send_byte(0, 8'hCC, 1'b1, 0);
    expect_block(0, LAT0, 0);
    chk_idle(0, "after_short");

    // full final block -> extra pad block
    send_block(0, 8'h10, 8, 1'b1, 0);
    expect_block(0, LAT0, 0);
    expect_block(0, LAT0, 0);
    chk_idle(0, "after_pad");

    // downstream stall with bytes offered, then a clean follow-up block
    send_block(0, 8'h40, 8, 1'b0, 0);
    expect_block(0, LAT0, 20);
    chk_idle(0, "after_stall");
    send_block(0, 8'h50, 2, 1'b1, 0);
    expect_block(0, LAT0, 0);

    // reset during FILL after 5 bytes
    send_block(0, 8'h20, 5, 1'b0, 0);
    rst = 1'b1;
    #1;
    chk_reset(0, "rst_fill");
    nb = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_block(0, 8'h60, 8, 1'b0, 0);
    expect_block(0, LAT0, 0);

    // reset during HOLD: nothing may be emitted for the aborted block
    send_block(0, 8'h70, 8, 1'b1, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset(0, "rst_hold");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rose = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ctv[0] !== 1'b0) rose = 1'b1;
    end
    chk("no_ct_after_abort", {63'd0, rose}, 64'd0);
    send_block(0, 8'h80, 8, 1'b0, 0);
    expect_block(0, LAT0, 0);

    // ENC_LATENCY=1 instance, gapped input with stray in_last
    send_block(1, 8'h90, 4, 1'b1, 2);
    expect_block(1, LAT1, 0);
    chk_idle(1, "lat1_short");
    send_block(1, 8'hA0, 8, 1'b0, 1);
    expect_block(1, LAT1, 0);
    chk_idle(1, "lat1_full");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/des_block_loader.md
Name: des_block_loader

Overview:
- Front-end sequencer for the DES encrypt stage. Accepts plaintext as a byte stream and packs it into 64-bit blocks.
- Applies PKCS#5 padding to the final block of each message.
- Drives each block onto the encrypt stage's msg input and holds it stable for the encrypt latency.
- Captures the encrypt stage's ciphertext output and presents it downstream through a valid/ready handshake.

Parameters:
- ENC_LATENCY, 16, clock cycles from msg stable to ciphertext valid at the encrypt stage's output (legal range 1..255).
- CNT_W, 8, width of the latency counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_byte  input  8  plaintext byte
- in_valid  input  1  in_byte valid
- in_last  input  1  marks the final byte of the message; qualified by in_valid
- in_ready  output  1  loader can accept a byte
- msg_out  output  64  block to the encrypt stage msg input; bits [63:56] carry the first byte (the encrypt stage's bit 1..8)
- enc_in  input  64  ciphertext from the encrypt stage output
- ct_out  output  64  captured ciphertext block
- ct_valid  output  1  ct_out valid
- ct_ready  input  1  downstream accepts ct_out
- ct_last  output  1  ct_out is the final block of the message
- busy  output  1  high in any state other than FILL, or when byte count is nonzero

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high.
- Reset values: state=FILL, byte count=0, msg_out=0, ct_out=0, ct_valid=0, ct_last=0, in_ready=1, busy=0, latency counter=0, pad_pending=0, last_flag=0.
- Reset asserted mid-operation aborts immediately. The partial block and any pending pad are discarded. No ciphertext is emitted for the aborted message.

FILL:
- in_ready=1.
- Byte accept: in_valid && in_ready. The byte is written to msg_out slot cnt, where slot 0 is [63:56] and slot 7 is [7:0]. cnt then increments.
- Accept without in_last at cnt==7: go to HOLD next cycle.
- Accept with in_last at cnt==k (k=0..6), i.e. n=k+1 bytes in the block:
  - slots k+1..7 are filled in the same cycle with the byte value 8-n;
  - last_flag=1; go to HOLD.
- Accept with in_last at cnt==7 (full block):
  - pad_pending=1; go to HOLD;
  - the following block is 0x0808080808080808 with last_flag=1.
- cnt wraps to 0 on entry to HOLD.

HOLD:
- in_ready=0. msg_out is held constant.
- The latency counter starts at 0 on entry and increments each cycle.
- In the cycle the counter equals ENC_LATENCY-1:
  - ct_out<=enc_in;
  - ct_last<=last_flag && !pad_pending;
  - ct_valid<=1 on the next edge; go to OUT.
- Cycles from entering HOLD to ct_valid high: exactly ENC_LATENCY.

OUT:
- ct_out, ct_valid and ct_last stay stable until ct_valid && ct_ready.
- On the handshake, ct_valid is deasserted next cycle, then:
  - if pad_pending: msg_out<=64'h0808080808080808, pad_pending<=0, last_flag<=1, go to HOLD;
  - else: last_flag<=0, msg_out<=0, go to FILL.
- A ct_ready held high is a single-cycle handshake. Back-to-back blocks therefore have a minimum period of 8 + ENC_LATENCY + 1 cycles.
- in_valid while in_ready=0 is ignored; upstream must hold the byte.
- in_last with in_valid=0 has no effect.
- Empty messages are not representable: in_last must accompany a byte.

Test Plan:
- Key 133457799BBCDFF1 with the real encrypt core; bytes 01 23 45 67 89 AB CD EF, no in_last -> msg_out=0123456789ABCDEF, ct_valid rises ENC_LATENCY cycles after HOLD entry, ct_out=85E813540F0AB405, ct_last=0.
- 3 bytes AA BB CC with in_last on CC -> msg_out=AABBCC0505050505; ct_last=1; return to FILL with busy=0.
- 8 bytes with in_last on the 8th -> two ciphertext blocks; the second is the encryption of 0808080808080808 with ct_last=1, and the first has ct_last=0.
- Hold ct_ready=0 for 20 cycles in OUT -> ct_out and ct_valid stable, in_ready=0, all offered bytes ignored; raise ct_ready -> one handshake, then FILL.
- Pulse rst after 5 bytes, and again during HOLD -> all outputs return to reset values within the cycle; the next 8 bytes form a clean new block.
- in_valid toggling 1-0-1 with gaps during FILL -> only qualified bytes are packed, in order; ENC_LATENCY=1 build gives ct_valid one cycle after HOLD entry.
